// File: rtl/ecc_lockstep_chk_if.sv
// Bus bundle for ecc_lockstep_chk: read-word inputs, controls, registered results and counters.
// in_vld qualifies data_in/parity_in for one cycle with no ready: every edge with in_vld=1 takes a word, and out_vld marks its result one cycle later.
interface ecc_lockstep_chk_if #(
  parameter int DATA_WIDTH   = 124,
  parameter int PARITY_WIDTH = 9,
  parameter int CNT_WIDTH    = 8
);
  logic                    in_vld;
  logic [DATA_WIDTH-1:0]   data_in;
  logic [PARITY_WIDTH-1:0] parity_in;
  logic                    bypass;
  logic                    chk_en;
  logic                    inj_en;
  logic                    cnt_clr;
  logic                    out_vld;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    sbit_err;
  logic                    dbit_err;
  logic                    ecc_fault;
  logic                    fault_sticky;
  logic [CNT_WIDTH-1:0]    sbit_cnt;
  logic [CNT_WIDTH-1:0]    dbit_cnt;
  logic [CNT_WIDTH-1:0]    fault_cnt;

  modport master (
    output in_vld, data_in, parity_in, bypass, chk_en, inj_en, cnt_clr,
    input  out_vld, data_out, sbit_err, dbit_err, ecc_fault, fault_sticky,
           sbit_cnt, dbit_cnt, fault_cnt
  );

  modport slave (
    input  in_vld, data_in, parity_in, bypass, chk_en, inj_en, cnt_clr,
    output out_vld, data_out, sbit_err, dbit_err, ecc_fault, fault_sticky,
           sbit_cnt, dbit_cnt, fault_cnt
  );
endinterface

// File: rtl/ecc_lockstep_chk.sv
// Lockstep SECDED read-path checker: two identical decoders, a result compare, registered
// outputs, saturating event counters, a sticky fault flag and a fault-injection hook.

// Extended Hamming decoder. Code positions 1..N: powers of two hold parity_in[k],
// the other positions hold data bits in ascending order; parity_in[MSB] is overall parity.
module ecc_124_cal #(
  parameter int DATA_WIDTH   = 124,
  parameter int PARITY_WIDTH = 9
) (
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [PARITY_WIDTH-1:0] parity_in,
  input  logic                    bypass,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    sbit_err,
  output logic                    dbit_err,
  output logic [DATA_WIDTH-1:0]   mask
);
  localparam int HW = PARITY_WIDTH - 1;

  function automatic int data_pos(input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 1; p < (1 << HW); p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] col_mask(input int k);
    logic [DATA_WIDTH-1:0] m;
    int cnt;
    m   = '0;
    cnt = 0;
    for (int p = 1; p < (1 << HW); p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt < DATA_WIDTH) m[cnt] = (((p >> k) & 1) != 0);
        cnt++;
      end
    end
    return m;
  endfunction

  localparam int            MAX_POS   = data_pos(DATA_WIDTH - 1);
  localparam logic [HW-1:0] MAX_POS_V = MAX_POS[HW-1:0];

  logic [HW-1:0]         syn;
  logic [DATA_WIDTH-1:0] hit;
  logic                  ovr;
  logic                  in_range;
  logic                  corr;

  for (genvar k = 0; k < HW; k++) begin : g_syn
    localparam logic [DATA_WIDTH-1:0] CM = col_mask(k);
    assign syn[k] = parity_in[k] ^ (^(data_in & CM));
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_hit
    localparam int P = data_pos(i);
    assign hit[i] = (syn == P[HW-1:0]);
  end

  assign ovr      = (^data_in) ^ (^parity_in);
  assign in_range = (syn <= MAX_POS_V);
  // Odd overall parity with a syndrome beyond the last code position cannot be a single flip.
  assign corr     = ~bypass & ovr & in_range;

  assign mask     = hit & {DATA_WIDTH{corr}};
  assign data_out = data_in ^ mask;
  assign sbit_err = corr;
  assign dbit_err = ~bypass & ((~ovr & (syn != '0)) | (ovr & ~in_range));
endmodule

module ecc_lockstep_chk #(
  parameter int DATA_WIDTH   = 124,
  parameter int PARITY_WIDTH = 9,
  parameter int CNT_WIDTH    = 8
) (
  input logic              clk,
  input logic              rst_n,
  ecc_lockstep_chk_if.slave bus
);
  logic [DATA_WIDTH-1:0] data0, data1, mask0, mask1, inj_vec;
  logic                  sbit0, sbit1, dbit0, dbit1;
  logic                  cmp_ok, fault_c;
  logic [DATA_WIDTH-1:0] data_c;

  logic                  out_vld_q, sbit_q, dbit_q, fault_q, sticky_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  sbit_cnt_q, dbit_cnt_q, fault_cnt_q;

  ecc_124_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_dec0 (
    .data_in  (bus.data_in),
    .parity_in(bus.parity_in),
    .bypass   (bus.bypass),
    .data_out (data0),
    .sbit_err (sbit0),
    .dbit_err (dbit0),
    .mask     (mask0)
  );

  ecc_124_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_dec1 (
    .data_in  (bus.data_in),
    .parity_in(bus.parity_in),
    .bypass   (bus.bypass),
    .data_out (data1),
    .sbit_err (sbit1),
    .dbit_err (dbit1),
    .mask     (mask1)
  );

  // Injection corrupts only copy 1's view so the comparator must trip.
  assign inj_vec = {{(DATA_WIDTH-1){1'b0}}, bus.inj_en};
  assign cmp_ok  = ({sbit0, dbit0, mask0} == {sbit1, dbit1, mask1 ^ inj_vec});
  assign fault_c = bus.in_vld & bus.chk_en & ~cmp_ok;
  assign data_c  = fault_c ? bus.data_in : data0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      sbit_q    <= 1'b0;
      dbit_q    <= 1'b0;
      fault_q   <= 1'b0;
      data_q    <= '0;
    end else if (bus.in_vld) begin
      out_vld_q <= 1'b1;
      sbit_q    <= sbit0;
      dbit_q    <= dbit0;
      fault_q   <= fault_c;
      data_q    <= data_c;
    end else begin
      out_vld_q <= 1'b0;
      sbit_q    <= 1'b0;
      dbit_q    <= 1'b0;
      fault_q   <= 1'b0;
    end
  end

  // Clear wins over a coincident event; that event is deliberately dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      fault_cnt_q <= '0;
      sticky_q    <= 1'b0;
    end else if (bus.cnt_clr) begin
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      fault_cnt_q <= '0;
      sticky_q    <= 1'b0;
    end else begin
      if (bus.in_vld && sbit0 && (sbit_cnt_q != '1)) sbit_cnt_q <= sbit_cnt_q + 1'b1;
      if (bus.in_vld && dbit0 && (dbit_cnt_q != '1)) dbit_cnt_q <= dbit_cnt_q + 1'b1;
      if (fault_c && (fault_cnt_q != '1))            fault_cnt_q <= fault_cnt_q + 1'b1;
      if (fault_c)                                   sticky_q <= 1'b1;
    end
  end

  assign bus.out_vld      = out_vld_q;
  assign bus.data_out     = data_q;
  assign bus.sbit_err     = sbit_q;
  assign bus.dbit_err     = dbit_q;
  assign bus.ecc_fault    = fault_q;
  assign bus.fault_sticky = sticky_q;
  assign bus.sbit_cnt     = sbit_cnt_q;
  assign bus.dbit_cnt     = dbit_cnt_q;
  assign bus.fault_cnt    = fault_cnt_q;
endmodule

// File: tb/tb_ecc_lockstep_chk.sv
// Directed and random checks of ecc_lockstep_chk against a codeword-level model
// (encode clean data, flip chosen code bits, predict flags, data and counters).
module tb_ecc_lockstep_chk;
  localparam int DW = 124;
  localparam int PW = 9;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // model state
  int          m_sbit_cnt, m_dbit_cnt, m_fault_cnt;
  bit          m_sticky;
  logic [DW-1:0] m_last_data;

  ecc_lockstep_chk_if #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  ecc_lockstep_chk #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
    logic [PW-1:0] p;
    int pos;
    p   = '0;
    pos = 1;
    for (int i = 0; i < DW; i++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      for (int k = 0; k < PW - 1; k++)
        if (((pos >> k) & 1) != 0) p[k] = p[k] ^ d[i];
      pos++;
    end
    p[PW-1] = (^d) ^ (^p[PW-2:0]);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit vld, input bit s, input bit d, input bit f);
    chk({tag, ".out_vld"},   128'(bus.out_vld),      128'(vld));
    chk({tag, ".data_out"},  128'(bus.data_out),     128'(m_last_data));
    chk({tag, ".sbit_err"},  128'(bus.sbit_err),     128'(s));
    chk({tag, ".dbit_err"},  128'(bus.dbit_err),     128'(d));
    chk({tag, ".ecc_fault"}, 128'(bus.ecc_fault),    128'(f));
    chk({tag, ".sticky"},    128'(bus.fault_sticky), 128'(m_sticky));
    chk({tag, ".sbit_cnt"},  128'(bus.sbit_cnt),     128'(m_sbit_cnt));
    chk({tag, ".dbit_cnt"},  128'(bus.dbit_cnt),     128'(m_dbit_cnt));
    chk({tag, ".fault_cnt"}, 128'(bus.fault_cnt),    128'(m_fault_cnt));
  endtask

  function automatic int sat_inc(input int v, input bit ev);
    return (ev && v < CNT_MAX) ? v + 1 : v;
  endfunction

  // driver: e0/e1 are code-bit indices to flip (0..DW-1 data, DW.. parity), -1 for none
  task automatic send(input string tag, input logic [DW-1:0] d, input int e0, input int e1,
                      input bit byp, input bit chk_e, input bit inj, input bit clr);
    logic [PW-1:0] p;
    logic [DW-1:0] raw;
    int nerr;
    bit es, ed, ef;
    p    = enc(d);
    raw  = d;
    nerr = 0;
    if (e0 >= 0) begin
      if (e0 < DW) raw[e0] = ~raw[e0]; else p[e0-DW] = ~p[e0-DW];
      nerr++;
    end
    if (e1 >= 0 && e1 != e0) begin
      if (e1 < DW) raw[e1] = ~raw[e1]; else p[e1-DW] = ~p[e1-DW];
      nerr++;
    end
    es = !byp && nerr == 1;
    ed = !byp && nerr == 2;
    ef = chk_e && inj;
    @(negedge clk);
    bus.in_vld    = 1'b1;
    bus.data_in   = raw;
    bus.parity_in = p;
    bus.bypass    = byp;
    bus.chk_en    = chk_e;
    bus.inj_en    = inj;
    bus.cnt_clr   = clr;
    @(posedge clk);
    m_last_data = ef ? raw : (es ? d : raw);
    if (clr) begin
      m_sbit_cnt = 0; m_dbit_cnt = 0; m_fault_cnt = 0; m_sticky = 0;
    end else begin
      m_sbit_cnt  = sat_inc(m_sbit_cnt, es);
      m_dbit_cnt  = sat_inc(m_dbit_cnt, ed);
      m_fault_cnt = sat_inc(m_fault_cnt, ef);
      if (ef) m_sticky = 1;
    end
    #1;
    chk_all(tag, 1'b1, es, ed, ef);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    bus.in_vld  = 1'b0;
    bus.cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    chk_all(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  initial begin
    logic [DW-1:0] base;
    int e0, e1, n;
    total = 0;
    bad   = 0;
    m_sbit_cnt = 0; m_dbit_cnt = 0; m_fault_cnt = 0; m_sticky = 0; m_last_data = '0;
    bus.in_vld = 0; bus.data_in = '0; bus.parity_in = '0; bus.bypass = 0;
    bus.chk_en = 1; bus.inj_en = 0; bus.cnt_clr = 0;

    // reset
    rst_n = 1'b0;
    #3;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // clean burst
    for (int i = 0; i < 10; i++) send("clean", rnd_data(), -1, -1, 0, 1, 0, 0);
    base = rnd_data();
    send("sbit37", base, 37, -1, 0, 1, 0, 0);
    send("dbit3_90", base, 3, 90, 0, 1, 0, 0);
    send("sbit_par", base, DW + 2, -1, 0, 1, 0, 0);
    send("sbit_ovr", base, DW + PW - 1, -1, 0, 1, 0, 0);
    idle("hold");
    idle("hold2");

    // injection, then sticky held over clean words
    send("clr", base, -1, -1, 0, 1, 0, 1);
    send("inj_sbit", rnd_data(), 11, -1, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) send("post_inj", rnd_data(), -1, -1, 0, 1, 0, 0);

    // clear collides with a faulty word
    send("clr_collide", rnd_data(), -1, -1, 0, 1, 1, 1);

    // bypass and chk_en=0 corners
    send("byp_err", rnd_data(), 5, 60, 1, 1, 0, 0);
    send("byp_inj", rnd_data(), 7, -1, 1, 1, 1, 0);
    send("nochk_inj", rnd_data(), 40, -1, 0, 0, 1, 0);

    // saturation
    send("sat_clr", rnd_data(), -1, -1, 0, 1, 0, 1);
    for (int i = 0; i < 20; i++) send("sat", rnd_data(), $urandom_range(0, DW - 1), -1, 0, 1, 0, 0);
    chk("sat_stop", 128'(bus.sbit_cnt), 128'(15));

    // random mix
    for (int i = 0; i < 300; i++) begin
      n  = $urandom_range(0, 2);
      e0 = (n >= 1) ? $urandom_range(0, DW + PW - 1) : -1;
      e1 = -1;
      if (n == 2) begin
        e1 = $urandom_range(0, DW + PW - 2);
        if (e1 >= e0) e1++;
      end
      if ($urandom_range(0, 9) == 0) idle("rnd_idle");
      send("rnd", rnd_data(), e0, e1, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);
    end

    // async reset between edges during a burst
    send("pre_rst", rnd_data(), -1, -1, 0, 1, 1, 0);
    send("pre_rst2", rnd_data(), 9, -1, 0, 1, 0, 0);
    #1;
    rst_n = 1'b0;
    m_sbit_cnt = 0; m_dbit_cnt = 0; m_fault_cnt = 0; m_sticky = 0; m_last_data = '0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    send("post_rst", rnd_data(), 17, -1, 0, 1, 0, 0);
    send("post_rst2", rnd_data(), -1, -1, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ecc_lockstep_chk.md
# ecc_lockstep_chk

Registered, parametrised lockstep ECC decode checker for FIFO/RAM read paths. Each valid read word is decoded by two identical SECDED decoder instances (`ecc_124_cal`, widths from parameters). Their syndrome-derived results are compared, and the corrected data and status are registered with a valid qualifier. The block also keeps saturating single-bit, double-bit and lockstep-fault counters, a sticky fault flag, and a deterministic fault-injection hook so safety logic can be self-tested in silicon.

## Interface
Parameters:
- `DATA_WIDTH`, 124, data bits per word.
- `PARITY_WIDTH`, 9, SECDED check bits; must match the decoder for `DATA_WIDTH`.
- `CNT_WIDTH`, 8, width of each saturating event counter.

Ports:
- `clk`, in, 1, single clock domain.
- `rst_n`, in, 1, asynchronous active-low reset.
- `in_vld`, in, 1, `data_in`/`parity_in` valid this cycle.
- `data_in`, in, `DATA_WIDTH`, raw read data.
- `parity_in`, in, `PARITY_WIDTH`, stored check bits.
- `bypass`, in, 1, decoders pass data through and report no errors.
- `chk_en`, in, 1, lockstep compare enable.
- `inj_en`, in, 1, inverts `mask[0]` of decoder copy 1 before the compare.
- `cnt_clr`, in, 1, synchronous clear of all counters and the sticky flag.
- `out_vld`, out, 1, registered outputs valid.
- `data_out`, out, `DATA_WIDTH`, corrected data, or raw data on a fault.
- `sbit_err`, out, 1, single-bit error, from copy 0.
- `dbit_err`, out, 1, double-bit error, from copy 0.
- `ecc_fault`, out, 1, lockstep mismatch on this word.
- `fault_sticky`, out, 1, set by any `ecc_fault` and held until `cnt_clr`.
- `sbit_cnt`, out, `CNT_WIDTH`, count of words with `sbit_err`.
- `dbit_cnt`, out, `CNT_WIDTH`, count of words with `dbit_err`.
- `fault_cnt`, out, `CNT_WIDTH`, count of words with `ecc_fault`.

## Operation
- Combinational stage:
  - Both copies decode the same `data_in`/`parity_in`/`bypass`.
  - `cmp_ok` = ({sbit0, dbit0, mask0} == {sbit1, dbit1, mask1'}), where mask1' = mask1 with bit 0 XOR `inj_en`.
  - fault_c = `in_vld` & `chk_en` & ~`cmp_ok`.
  - data_c = fault_c ? `data_in` : data_out0.
- Register stage: on an edge where `in_vld`=1, load `data_out`, `sbit_err`, `dbit_err` and `ecc_fault` from the combinational values, and set `out_vld`=1.
- On an edge where `in_vld`=0:
  - `out_vld` goes to 0.
  - `sbit_err`, `dbit_err` and `ecc_fault` go to 0.
  - `data_out` holds its last value.
- Counters:
  - On the same edge that registers a word, each counter increments by 1 if its flag is set, with no wrap.
  - Each counter saturates at 2^`CNT_WIDTH`−1.
  - Counters increment independently, so one word may bump `sbit_cnt` and `fault_cnt` together.
- `fault_sticky` is set on any edge that registers `ecc_fault`=1.
- `cnt_clr` has priority: on a `cnt_clr` edge, all counters and `fault_sticky` go to 0 even if an event occurs on that edge; the event is lost.
  - `cnt_clr` does not affect `out_vld`, `data_out` or the error flags.
- With `bypass`=1, both copies report no error and masks of 0. No sbit/dbit counting occurs. A fault is still possible when `inj_en`=1.
- With `chk_en`=0, `ecc_fault` stays 0, `data_out` is copy 0 output, and `inj_en` has no effect.

## Timing
- Latency is 1 cycle: a word presented with `in_vld` at edge N appears with `out_vld` after edge N. Counters reflect the word in the same cycle as `out_vld`.
- Throughput is 1 word per cycle; there is no backpressure.
- Reset (`rst_n`=0, async) values:
  - `out_vld`, `sbit_err`, `dbit_err`, `ecc_fault`, `fault_sticky`: 0.
  - `data_out`: all zeros.
  - all counters: 0.
- Reset asserted mid-stream drops the in-flight word. The first word after deassertion is accepted on the first rising edge with `rst_n`=1.
- `inj_en`, `chk_en` and `bypass` are sampled per word, combinationally with `in_vld`.

## Test plan
- Clean word with `chk_en`=1, `inj_en`=0, 10 consecutive `in_vld` cycles:
  - `out_vld` high for cycles 1–10 after the first edge.
  - `data_out` equals `data_in`.
  - all flags 0 and all counters 0.
- Single bit flip of `data_in[37]`:
  - next cycle `sbit_err`=1 and `data_out` is corrected.
  - `sbit_cnt`=1, `ecc_fault`=0.
  - Double flip of bits [3,90]: `dbit_err`=1, `dbit_cnt`=1.
- Injection with `inj_en`=1, `chk_en`=1, one single-bit-error word:
  - `ecc_fault`=1 and `data_out` equals raw `data_in`.
  - `sbit_cnt`=1, `fault_cnt`=1, `fault_sticky`=1.
  - `fault_sticky` stays 1 over 5 following clean words.
- Saturation with `CNT_WIDTH`=4 and 20 single-error words: `sbit_cnt` stops at 15.
- Clear collision: `cnt_clr` asserted on the same edge as a faulty word → `fault_cnt`=0 and `fault_sticky`=0, while `ecc_fault`=1 for that word.
- Asynchronous reset pulse between edges during a burst:
  - all outputs go to 0 immediately.
  - after release, the next word appears 1 cycle after it is presented.
